// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue: FSM state encoding and
// the sequential-PC increment used to build fall-through redirect targets.
package branch_resolve_queue_pkg;

  // RUN: normal push/pop; FLUSH: one-cycle bubble after a misprediction
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } brq_state_e;

  // Fixed instruction size; fall-through PC is entry PC + PC_INC
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Handshake and result bundle for the branch resolve queue.
//   push_*    : fetch-side prediction push (valid/ready)
//   ex_*      : execute-side outcome (valid/ready), pops the oldest entry
//   resolve_* : predictor training port
//   flush / redirect_pc : pipeline restart request
//   occupancy / mispredict_count : status
// slave modport faces the queue, master modport faces the pipeline.
interface branch_resolve_queue_if #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                push_valid;
  logic                push_ready;
  logic [PC_WIDTH-1:0] push_pc;
  logic [PC_WIDTH-1:0] push_pred_target;
  logic                push_pred_taken;

  logic                ex_valid;
  logic                ex_ready;
  logic                ex_is_branch;
  logic                ex_taken;
  logic [PC_WIDTH-1:0] ex_target;

  logic                resolve_valid;
  logic                resolve_taken;
  logic [PC_WIDTH-1:0] resolve_pc;
  logic [PC_WIDTH-1:0] resolve_target;

  logic                flush;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [CW-1:0]       occupancy;
  logic [31:0]         mispredict_count;

  modport slave (
    input  push_valid, push_pc, push_pred_target, push_pred_taken,
    input  ex_valid, ex_is_branch, ex_taken, ex_target,
    output push_ready, ex_ready,
    output resolve_valid, resolve_taken, resolve_pc, resolve_target,
    output flush, redirect_pc, occupancy, mispredict_count
  );

  modport master (
    output push_valid, push_pc, push_pred_target, push_pred_taken,
    output ex_valid, ex_is_branch, ex_taken, ex_target,
    input  push_ready, ex_ready,
    input  resolve_valid, resolve_taken, resolve_pc, resolve_target,
    input  flush, redirect_pc, occupancy, mispredict_count
  );

endinterface

// File: rtl/branch_resolve_queue_pred_fifo.sv
// pred_fifo: circular FIFO of in-flight predictions (pc, predicted target,
// predicted direction). The head entry is presented combinationally.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push_en / pop_en    : write tail / advance head (caller guarantees legality)
//   clear               : empty the queue, dropping any same-cycle push
//   wr_*                : entry to write
//   rd_*_c              : head entry
//   count               : number of stored entries
module pred_fifo #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push_en,
  input  logic                               pop_en,
  input  logic                               clear,
  input  logic [PC_WIDTH-1:0]                wr_pc,
  input  logic [PC_WIDTH-1:0]                wr_target,
  input  logic                               wr_taken,
  output logic [PC_WIDTH-1:0]                rd_pc_c,
  output logic [PC_WIDTH-1:0]                rd_target_c,
  output logic                               rd_taken_c,
  output logic [$clog2(DEPTH):0]             count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PC_WIDTH-1:0] mem_pc     [DEPTH];
  logic [PC_WIDTH-1:0] mem_target [DEPTH];
  logic                mem_taken  [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_en && !clear) begin
      mem_pc[wr_ptr]     <= wr_pc;
      mem_target[wr_ptr] <= wr_target;
      mem_taken[wr_ptr]  <= wr_taken;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  assign rd_pc_c     = mem_pc[rd_ptr];
  assign rd_target_c = mem_target[rd_ptr];
  assign rd_taken_c  = mem_taken[rd_ptr];

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: holds fetch-time branch predictions in order, checks
// each against its executed outcome, trains the predictor and requests a
// flush/redirect on a misprediction.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_resolve_queue_if.slave (push, execute, resolve,
//              flush/redirect and status signals)
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_queue_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  brq_state_e          state;
  brq_state_e          next_state_c;
  logic [CW-1:0]       count;
  logic [CW-1:0]       next_count_c;
  logic [PC_WIDTH-1:0] head_pc_c;
  logic [PC_WIDTH-1:0] head_target_c;
  logic                head_taken_c;
  logic                push_fire_c;
  logic                pop_fire_c;
  logic                mispredict_c;
  logic                fifo_push_c;
  logic                clear_c;
  logic [PC_WIDTH-1:0] redirect_c;

  pred_fifo #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH)
  ) u_pred_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_en     (fifo_push_c),
    .pop_en      (pop_fire_c),
    .clear       (clear_c),
    .wr_pc       (bus.push_pc),
    .wr_target   (bus.push_pred_target),
    .wr_taken    (bus.push_pred_taken),
    .rd_pc_c     (head_pc_c),
    .rd_target_c (head_target_c),
    .rd_taken_c  (head_taken_c),
    .count       (count)
  );

  // Handshakes, misprediction check and next-state/occupancy decode
  always_comb begin
    push_fire_c  = bus.push_valid & bus.push_ready;
    pop_fire_c   = bus.ex_valid & bus.ex_ready;
    mispredict_c = 1'b0;
    if (pop_fire_c) begin
      if (bus.ex_is_branch)
        mispredict_c = (head_taken_c != bus.ex_taken) ||
                       (head_taken_c && bus.ex_taken && (head_target_c != bus.ex_target));
      else
        mispredict_c = head_taken_c;
    end
    clear_c     = mispredict_c;
    fifo_push_c = push_fire_c & ~mispredict_c;

    if (clear_c) next_count_c = '0;
    else         next_count_c = count + CW'(fifo_push_c) - CW'(pop_fire_c);

    next_state_c = RUN;
    if (state == RUN && mispredict_c) next_state_c = FLUSH;

    if (bus.ex_is_branch && bus.ex_taken) redirect_c = bus.ex_target;
    else                                  redirect_c = head_pc_c + PC_WIDTH'(PC_INC);
  end

  // State and registered outputs; readies are precomputed for the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= RUN;
      bus.push_ready       <= 1'b1;
      bus.ex_ready         <= 1'b0;
      bus.resolve_valid    <= 1'b0;
      bus.resolve_taken    <= 1'b0;
      bus.resolve_pc       <= '0;
      bus.resolve_target   <= '0;
      bus.flush            <= 1'b0;
      bus.redirect_pc      <= '0;
      bus.mispredict_count <= '0;
    end else begin
      state             <= next_state_c;
      bus.push_ready    <= (next_state_c == RUN) && (next_count_c < CW'(DEPTH));
      bus.ex_ready      <= (next_state_c == RUN) && (next_count_c != '0);
      bus.resolve_valid <= pop_fire_c & bus.ex_is_branch;
      if (pop_fire_c) begin
        bus.resolve_pc     <= head_pc_c;
        bus.resolve_taken  <= bus.ex_taken;
        bus.resolve_target <= bus.ex_target;
      end
      bus.flush <= mispredict_c;
      if (mispredict_c) begin
        bus.redirect_pc      <= redirect_c;
        bus.mispredict_count <= bus.mispredict_count + 32'd1;
      end
    end
  end

  assign bus.occupancy = count;

endmodule
